// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer
// Walks the sample ROM at a fixed address step, prefetches samples into a
// small FIFO and hands one sample to both DAC channels on every codec
// frame-done edge. The asynchronous frame-done input is synchronised and
// edge-detected here, so the whole block runs on Clk.
module audio_sample_streamer #(
    parameter int                ADDR_W    = 20,
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_STEP = 4,
    parameter logic [ADDR_W-1:0] END_ADDR  = 20'hFFFFC
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Loop,
    input  logic              data_over,
    output logic [ADDR_W-1:0] ROM_ADDR,
    input  logic [DATA_W-1:0] ROM_DATA,
    output logic [DATA_W-1:0] LDATA_out,
    output logic [DATA_W-1:0] RDATA_out,
    output logic              Busy,
    output logic              Done,
    output logic              Underrun
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [ADDR_W-1:0] STEP_C    = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]    ROOM_LIM  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                sync1_r;
    logic                sync2_r;
    logic                prev_r;
    logic                inflight_r;
    logic [CNT_W-1:0]    count_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [DATA_W-1:0]   fifo_r [DEPTH];
    logic [ADDR_W-1:0]   addr_next_s;
    logic                at_end_s;
    logic                room_s;
    logic                issue_s;
    logic                active_s;
    logic                pop_s;
    logic                pop_hit_s;
    logic                pop_empty_s;
    logic                push_s;
    logic                start_fill_s;

    // Reads are throttled so that stored plus outstanding samples never
    // exceed the FIFO depth; this is what makes an overflow path unnecessary.
    assign at_end_s     = (ROM_ADDR == END_ADDR);
    assign room_s       = ({1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r}) < ROOM_LIM;
    assign issue_s      = ((state_r == ST_FILL) || (state_r == ST_PLAY)) && !inflight_r && room_s;
    assign active_s     = (state_r == ST_PLAY) || (state_r == ST_DRAIN);
    assign pop_s        = active_s && sync2_r && !prev_r;
    assign pop_hit_s    = pop_s && (count_r != CNT_ZERO);
    assign pop_empty_s  = pop_s && (count_r == CNT_ZERO);
    assign push_s       = inflight_r;
    assign start_fill_s = (state_r == ST_IDLE) && Start;

    // Two-flop synchroniser plus previous-value flop for data_over edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= data_over;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state and next-read-address decode
    always_comb begin
        state_s     = state_r;
        addr_next_s = ROM_ADDR;
        if (issue_s) begin
            if (at_end_s) begin
                // Without looping the address parks on END_ADDR so it is never exceeded
                if (Loop) begin
                    addr_next_s = ADDR_ZERO;
                end else begin
                    addr_next_s = ROM_ADDR;
                end
            end else begin
                addr_next_s = ROM_ADDR + STEP_C;
            end
        end else if (start_fill_s) begin
            addr_next_s = ADDR_ZERO;
        end else begin
            addr_next_s = ROM_ADDR;
        end

        case (state_r)
            ST_IDLE: begin
                if (Start) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                // A very short sample table can end before the FIFO ever fills
                if (issue_s && at_end_s && !Loop) begin
                    state_s = ST_DRAIN;
                end else if (count_r == CNT_FULL) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_PLAY: begin
                if (issue_s && at_end_s && !Loop) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DRAIN: begin
                // Finished once the last stored sample is popped and nothing is outstanding
                if (!inflight_r && ((count_r == CNT_ZERO) || (pop_hit_s && (count_r == CNT_ONE)))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!Start) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with registered Busy/Done decodes of the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_r <= state_s;
            Busy    <= (state_s == ST_FILL) || (state_s == ST_PLAY) || (state_s == ST_DRAIN);
            Done    <= (state_s == ST_DONE);
        end
    end

    // ROM address and single outstanding-read tracker
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ROM_ADDR   <= ADDR_ZERO;
            inflight_r <= 1'b0;
        end else begin
            ROM_ADDR   <= addr_next_s;
            inflight_r <= issue_s;
        end
    end

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge Clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= ROM_DATA;
        end
    end

    // FIFO pointers and occupancy, cleared on reset and on every new playback
    always_ff @(posedge Clk) begin
        if (Reset || start_fill_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_hit_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_hit_s);
        end
    end

    // Output sample registers: head on a good pop, silence on an empty pop
    always_ff @(posedge Clk) begin
        if (Reset) begin
            LDATA_out <= DATA_ZERO;
            RDATA_out <= DATA_ZERO;
        end else if (pop_hit_s) begin
            LDATA_out <= fifo_r[rd_ptr_r];
            RDATA_out <= fifo_r[rd_ptr_r];
        end else if (pop_empty_s) begin
            LDATA_out <= DATA_ZERO;
            RDATA_out <= DATA_ZERO;
        end
    end

    // Sticky underrun flag, cleared only by reset or a fresh start
    always_ff @(posedge Clk) begin
        if (Reset || start_fill_s) begin
            Underrun <= 1'b0;
        end else if (pop_empty_s) begin
            Underrun <= 1'b1;
        end
    end

endmodule
